opb_event_counter_bank: RTL and testbench



---
 rtl/opb_event_counter_bank.sv | 158 +++++++++++++++
 tb/tb_opb_event_counter_bank.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_event_counter_bank.sv
// OPB slave holding a bank of event counters with snapshot registers.
// Overflow flags are sticky and cleared by writing ones.
module opb_event_counter_bank #(
  parameter logic [31:0] C_BASEADDR   = 32'hFFFFFFFF,
  parameter logic [31:0] C_HIGHADDR   = 32'h00000000,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5",
  parameter int          C_NUM_CH     = 4,
  parameter int          C_CNT_WIDTH  = 32,
  parameter int          C_SATURATE   = 0
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [C_NUM_CH-1:0]     event_in,
  output logic [C_NUM_CH-1:0]     ovf_flag
);

  localparam logic [C_CNT_WIDTH-1:0] LP_MAX = {C_CNT_WIDTH{1'b1}};
  localparam logic [C_CNT_WIDTH-1:0] LP_ONE = C_CNT_WIDTH'(1);

  logic                    r_ack;
  logic [31:0]             r_dbus;
  logic                    r_wr;
  logic [5:0]              r_off;
  logic [31:0]             r_wdata;
  logic                    r_be_b0;
  logic                    r_be_hw;
  logic [C_CNT_WIDTH-1:0]  r_cnt  [C_NUM_CH];
  logic [C_CNT_WIDTH-1:0]  r_snap [C_NUM_CH];
  logic [C_NUM_CH-1:0]     r_flag;

  logic [0:C_OPB_AWIDTH-1] w_rel;
  logic [5:0]              w_off;
  logic                    w_hit;
  logic                    w_start;
  logic [31:0]             w_ctrl;
  logic [31:0]             w_rdata;
  logic                    w_wr_act;
  logic                    w_snap;
  logic                    w_clr;
  logic [C_NUM_CH-1:0]     w_w1c;
  logic [C_NUM_CH-1:0]     w_ovf;
  logic                    w_unused;

  assign w_rel = OPB_ABus - C_BASEADDR;
  assign w_off = w_rel[24:29];
  assign w_hit = OPB_select
              && (OPB_ABus >= C_BASEADDR)
              && (OPB_ABus <= C_HIGHADDR);
  // A new transfer may only start while no ack is showing.
  assign w_start = w_hit & ~r_ack;

  assign w_ctrl = {8'(C_NUM_CH), 8'(C_CNT_WIDTH),
                   15'd0, 1'(C_SATURATE)};

  always_comb begin
    w_rdata = '0;
    if (w_off == 6'd0) begin
      w_rdata = w_ctrl;
    end else if (w_off == 6'd1) begin
      w_rdata = 32'(r_flag);
    end else begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        if (w_off == 6'(i + 2)) begin
          w_rdata = 32'(r_snap[i]);
        end
      end
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_ack   <= 1'b0;
      r_dbus  <= '0;
      r_wr    <= 1'b0;
      r_off   <= '0;
      r_wdata <= '0;
      r_be_b0 <= 1'b0;
      r_be_hw <= 1'b0;
    end else begin
      r_ack  <= w_start;
      r_dbus <= (w_start && OPB_RNW) ? w_rdata : '0;
      r_wr   <= w_start & ~OPB_RNW;
      if (w_start) begin
        r_off   <= w_off;
        r_wdata <= OPB_DBus;
        r_be_b0 <= OPB_BE[3];
        r_be_hw <= OPB_BE[2] | OPB_BE[3];
      end
    end
  end

  // Writes take effect at the end of the ack cycle.
  assign w_wr_act = r_ack & r_wr;
  assign w_snap = w_wr_act && (r_off == 6'd0)
               && r_be_b0 && r_wdata[0];
  assign w_clr  = w_wr_act && (r_off == 6'd0)
               && r_be_b0 && r_wdata[1];
  assign w_w1c  = (w_wr_act && (r_off == 6'd1) && r_be_hw)
               ? r_wdata[C_NUM_CH-1:0] : '0;

  always_comb begin
    w_ovf = '0;
    for (int i = 0; i < C_NUM_CH; i++) begin
      w_ovf[i] = event_in[i] & ~w_clr & (r_cnt[i] == LP_MAX);
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        r_cnt[i]  <= '0;
        r_snap[i] <= '0;
      end
      r_flag <= '0;
    end else begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        if (w_snap) begin
          r_snap[i] <= r_cnt[i];
        end
        if (w_clr) begin
          r_cnt[i] <= C_CNT_WIDTH'(event_in[i]);
        end else if (event_in[i]) begin
          if (w_ovf[i]) begin
            r_cnt[i] <= (C_SATURATE != 0) ? LP_MAX : '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + LP_ONE;
          end
        end
      end
      // A fresh overflow wins over a simultaneous clear.
      r_flag <= (r_flag & ~w_w1c) | w_ovf;
    end
  end

  assign Sl_DBus    = r_dbus;
  assign Sl_xferAck = r_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign ovf_flag   = r_flag;

  assign w_unused = ^{OPB_seqAddr, OPB_BE[0:1], w_rel,
                      r_wdata, C_FAMILY};

endmodule

// File: tb/tb_opb_event_counter_bank.sv
// Bench for opb_event_counter_bank: three configurations share one bus,
// a behavioural model predicts read data into a scoreboard queue.
module tb_opb_event_counter_bank;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] HIGH = 32'h8000_00FF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw;
  logic        sel;
  logic        seq;
  logic [3:0]  ev;

  logic [31:0] s_dbus [3];
  logic        ack  [3];
  logic        err  [3];
  logic        rty  [3];
  logic        tout [3];
  logic [3:0]  ovf  [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  opb_event_counter_bank #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH)
  ) u0 (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be),
    .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel),
    .OPB_seqAddr(seq), .Sl_DBus(s_dbus[0]), .Sl_xferAck(ack[0]),
    .Sl_errAck(err[0]), .Sl_retry(rty[0]), .Sl_toutSup(tout[0]),
    .event_in(ev), .ovf_flag(ovf[0])
  );

  opb_event_counter_bank #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH),
    .C_CNT_WIDTH(4), .C_SATURATE(0)
  ) u1 (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be),
    .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel),
    .OPB_seqAddr(seq), .Sl_DBus(s_dbus[1]), .Sl_xferAck(ack[1]),
    .Sl_errAck(err[1]), .Sl_retry(rty[1]), .Sl_toutSup(tout[1]),
    .event_in(ev), .ovf_flag(ovf[1])
  );

  opb_event_counter_bank #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH),
    .C_CNT_WIDTH(4), .C_SATURATE(1)
  ) u2 (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be),
    .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel),
    .OPB_seqAddr(seq), .Sl_DBus(s_dbus[2]), .Sl_xferAck(ack[2]),
    .Sl_errAck(err[2]), .Sl_retry(rty[2]), .Sl_toutSup(tout[2]),
    .event_in(ev), .ovf_flag(ovf[2])
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // behavioural model
  int          W   [3] = '{32, 4, 4};
  int          SAT [3] = '{0, 0, 1};
  logic [31:0] m_cnt  [3][4];
  logic [31:0] m_snap [3][4];
  logic [3:0]  m_flag [3];
  bit          pend_snap = 1'b0;
  bit          pend_clr  = 1'b0;
  logic [3:0]  pend_w1c  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < 4; i++) begin
          m_cnt[d][i]  = '0;
          m_snap[d][i] = '0;
        end
        m_flag[d] = '0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        logic [31:0] mx;
        logic [3:0]  setf;
        mx = (W[d] == 32) ? 32'hFFFF_FFFF : (32'h1 << W[d]) - 32'h1;
        setf = '0;
        for (int i = 0; i < 4; i++) begin
          if (pend_snap) m_snap[d][i] = m_cnt[d][i];
          if (pend_clr) begin
            m_cnt[d][i] = {31'd0, ev[i]};
          end else if (ev[i]) begin
            if (m_cnt[d][i] == mx) begin
              setf[i] = 1'b1;
              m_cnt[d][i] = (SAT[d] != 0) ? mx : 32'h0;
            end else begin
              m_cnt[d][i] = m_cnt[d][i] + 32'h1;
            end
          end
        end
        m_flag[d] = (m_flag[d] & ~pend_w1c) | setf;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input int d,
                                         input logic [5:0] off);
    logic [31:0] r;
    r = '0;
    if (off == 6'd0) begin
      r = {8'd4, 8'(W[d]), 15'd0, 1'(SAT[d])};
    end else if (off == 6'd1) begin
      r = {28'd0, m_flag[d]};
    end else if (off >= 6'd2 && off <= 6'd5) begin
      r = m_snap[d][off - 6'd2];
    end
    return r;
  endfunction

  typedef struct {
    string       tag;
    logic [31:0] e [3];
  } sb_t;

  sb_t q [$];

  always @(negedge clk) begin
    if (!rst && (ack[0] || ack[1] || ack[2])) begin
      if (q.size() == 0) begin
        check("spurious_ack", 32'd1, 32'd0);
      end else begin
        sb_t s;
        s = q.pop_front();
        for (int d = 0; d < 3; d++) begin
          check($sformatf("%s/u%0d", s.tag, d), s_dbus[d], s.e[d]);
          check($sformatf("ties/u%0d", d),
                32'({err[d], rty[d], tout[d]}), 32'd0);
        end
      end
    end
  end

  // Called right after a falling edge; returns right after one.
  task automatic xfer(input bit rd, input logic [7:0] boff,
                      input logic [31:0] data,
                      input logic [0:3] be_i, input string tag);
    sb_t s;
    logic [5:0] off;
    off  = boff[7:2];
    abus = BASE + {24'd0, boff};
    dbus = data;
    be   = be_i;
    rnw  = rd;
    sel  = 1'b1;
    s.tag = tag;
    for (int d = 0; d < 3; d++) s.e[d] = rd ? exp_rd(d, off) : '0;
    q.push_back(s);
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("%s_ack/u%0d", tag, d), 32'(ack[d]), 32'd1);
    sel = 1'b0;
    if (!rd) begin
      pend_snap = (off == 6'd0) && be_i[3] && data[0];
      pend_clr  = (off == 6'd0) && be_i[3] && data[1];
      pend_w1c  = ((off == 6'd1) && (be_i[2] || be_i[3]))
                ? data[3:0] : 4'd0;
    end
    @(negedge clk);
    pend_snap = 1'b0;
    pend_clr  = 1'b0;
    pend_w1c  = '0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_1cyc/u%0d", tag, d), 32'(ack[d]), 32'd0);
      check($sformatf("%s_idle/u%0d", tag, d), s_dbus[d], 32'd0);
    end
  endtask

  task automatic chk_ovf(input string tag);
    for (int d = 0; d < 3; d++)
      check($sformatf("%s/u%0d", tag, d), 32'(ovf[d]), 32'(m_flag[d]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    abus = '0; dbus = '0; be = '0; rnw = 1'b1;
    sel = 1'b0; seq = 1'b0; ev = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ack/u%0d", d), 32'(ack[d]), 32'd0);
      check($sformatf("rst_dbus/u%0d", d), s_dbus[d], 32'd0);
      check($sformatf("rst_ovf/u%0d", d), 32'(ovf[d]), 32'd0);
    end
    rst = 1'b0;

    ev = 4'b0001;
    repeat (10) @(negedge clk);
    ev = 4'b0000;
    xfer(0, 8'h00, 32'h1, 4'b0001, "snap10");
    xfer(1, 8'h08, 32'h0, 4'b1111, "rd_ch0");
    xfer(1, 8'h0C, 32'h0, 4'b1111, "rd_ch1");

    xfer(0, 8'h00, 32'h2, 4'b0001, "clr");
    ev = 4'b0010;
    repeat (17) @(negedge clk);
    ev = 4'b0000;
    xfer(0, 8'h00, 32'h1, 4'b0001, "snap17");
    xfer(1, 8'h0C, 32'h0, 4'b1111, "rd17_ch1");
    xfer(1, 8'h04, 32'h0, 4'b1111, "flags17");
    chk_ovf("ovf17");
    xfer(0, 8'h04, 32'h2, 4'b0011, "w1c");
    xfer(1, 8'h04, 32'h0, 4'b1111, "flags_w1c");

    xfer(0, 8'h00, 32'h2, 4'b0001, "clr2");
    ev = 4'b0001;
    repeat (20) @(negedge clk);
    ev = 4'b0000;
    xfer(0, 8'h00, 32'h1, 4'b0001, "snap20");
    xfer(1, 8'h08, 32'h0, 4'b1111, "rd20_ch0");
    chk_ovf("ovf20");

    ev = 4'b0001;
    xfer(0, 8'h04, 32'hF, 4'b0001, "w1c_race");
    xfer(0, 8'h00, 32'h3, 4'b1110, "ctrl_nobe");
    ev = 4'b0000;
    xfer(1, 8'h04, 32'h0, 4'b1111, "flags_race");
    xfer(1, 8'h08, 32'h0, 4'b1111, "rd_nobe");

    xfer(0, 8'h00, 32'h2, 4'b0001, "clr3");
    ev = 4'b0100;
    repeat (3) @(negedge clk);
    xfer(0, 8'h00, 32'h3, 4'b0001, "snapclr");
    xfer(1, 8'h10, 32'h0, 4'b1111, "rd_ch2_a");
    xfer(0, 8'h00, 32'h1, 4'b0001, "snap_re");
    xfer(1, 8'h10, 32'h0, 4'b1111, "rd_ch2_b");
    ev = 4'b0000;

    xfer(1, 8'h00, 32'h0, 4'b1111, "ctrl");
    xfer(1, 8'hFC, 32'h0, 4'b1111, "off3f");
    xfer(1, 8'h18, 32'h0, 4'b1111, "off6");
    xfer(0, 8'h10, 32'hFFFF_FFFF, 4'b1111, "wr_snap");
    xfer(0, 8'h40, 32'hFFFF_FFFF, 4'b1111, "wr_unmap");
    xfer(1, 8'h10, 32'h0, 4'b1111, "rd_ch2_c");
    xfer(1, 8'h04, 32'h0, 4'b1111, "flags_c");

    abus = BASE + 32'h100;
    rnw = 1'b1;
    sel = 1'b1;
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        check($sformatf("miss/u%0d", d), 32'(ack[d]), 32'd0);
    end
    sel = 1'b0;

    ev = 4'b1111;
    repeat (20) @(negedge clk);
    abus = BASE + 32'h4;
    rnw = 1'b1;
    sel = 1'b1;
    #3 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("rstx_ack/u%0d", d), 32'(ack[d]), 32'd0);
        check($sformatf("rstx_ovf/u%0d", d), 32'(ovf[d]), 32'd0);
      end
    end
    sel = 1'b0;
    ev = 4'b0000;
    rst = 1'b0;
    @(negedge clk);
    xfer(0, 8'h00, 32'h1, 4'b0001, "snap_rst");
    xfer(1, 8'h08, 32'h0, 4'b1111, "rst_ch0");
    xfer(1, 8'h14, 32'h0, 4'b1111, "rst_ch3");
    xfer(1, 8'h04, 32'h0, 4'b1111, "rst_flags");
    chk_ovf("ovf_end");

    check("sb_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
